// File: rtl/tdm_demux4_if.sv
// Serial TDM link bundle: serial bit/sync input plus parallel channel outputs and status.
interface tdm_demux4_if #(
   parameter int unsigned SLOT_W = 8
);
   logic              en;
   logic              din;
   logic              fs;
   logic [SLOT_W-1:0] ch0;
   logic [SLOT_W-1:0] ch1;
   logic [SLOT_W-1:0] ch2;
   logic [SLOT_W-1:0] ch3;
   logic              frame_valid;
   logic              locked;
   logic              sync_err;

   // Drives the serial stream and observes decoded channels.
   modport master (
      output en, din, fs,
      input  ch0, ch1, ch2, ch3, frame_valid, locked, sync_err
   );

   // The demultiplexer itself.
   modport slave (
      input  en, din, fs,
      output ch0, ch1, ch2, ch3, frame_valid, locked, sync_err
   );
endinterface

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: hunts for frame sync, shifts in four MSB-first slots
// and presents them as registered parallel words with a one-cycle frame strobe.
module tdm_demux4 #(
   parameter int unsigned SLOT_W = 8
) (
   input logic         clk,
   input logic         rst_n,
   tdm_demux4_if.slave bus
);

   localparam int unsigned FrameLen = 4 * SLOT_W;
   localparam int unsigned CntW     = $clog2(FrameLen);
   localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen - 1);

   typedef enum logic [0:0] {StHunt, StRecv} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [FrameLen-1:0] sr_q, sr_d;
   logic [FrameLen-1:0] sr_shift;
   logic [SLOT_W-1:0]   ch0_q, ch1_q, ch2_q, ch3_q;
   logic                frame_valid_q, sync_err_q;
   logic                frame_load, frame_err, locked;

   // Incoming bit appended at the LSB end; frame bit 0 ends up in the MSB.
   assign sr_shift = {sr_q[FrameLen-2:0], bus.din};

   // State, bit counter and shift register; frozen on en=0 cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StHunt;
         cnt_q   <= '0;
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
      end
   end

   // Next-state: frame acquisition, bit counting and resync on misplaced fs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      if (bus.en) begin
         unique case (state_q)
            StHunt: begin
               if (bus.fs) begin
                  state_d = StRecv;
                  cnt_d   = CntW'(1);
                  sr_d    = sr_shift;
               end
            end
            StRecv: begin
               if (bus.fs) begin
                  // Normal frame start or misplaced sync: either way this is bit 0.
                  cnt_d = CntW'(1);
                  sr_d  = sr_shift;
               end else if (cnt_q == '0) begin
                  state_d = StHunt;
               end else begin
                  sr_d  = sr_shift;
                  cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
               end
            end
            default: state_d = StHunt;
         endcase
      end
   end

   // Output decode: frame completion, alignment violation and lock indication.
   always_comb begin
      locked     = (state_q == StRecv);
      frame_load = bus.en && locked && !bus.fs && (cnt_q == LastCnt);
      frame_err  = bus.en && locked && (bus.fs ? (cnt_q != '0) : (cnt_q == '0));
   end

   // Registered channel words and one-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch0_q         <= '0;
         ch1_q         <= '0;
         ch2_q         <= '0;
         ch3_q         <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         frame_valid_q <= frame_load;
         sync_err_q    <= frame_err;
         if (frame_load) begin
            ch0_q <= sr_shift[4*SLOT_W-1 -: SLOT_W];
            ch1_q <= sr_shift[3*SLOT_W-1 -: SLOT_W];
            ch2_q <= sr_shift[2*SLOT_W-1 -: SLOT_W];
            ch3_q <= sr_shift[SLOT_W-1 -: SLOT_W];
         end
      end
   end

   assign bus.ch0         = ch0_q;
   assign bus.ch1         = ch1_q;
   assign bus.ch2         = ch2_q;
   assign bus.ch3         = ch3_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.sync_err    = sync_err_q;
   assign bus.locked      = locked;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 at SLOT_W=8.
module tb_tdm_demux4;

   localparam int unsigned SLOT_W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;

   tdm_demux4_if #(.SLOT_W(SLOT_W)) bus ();

   tdm_demux4 #(.SLOT_W(SLOT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Apply one input vector mid-cycle, then return just after the sampling edge.
   task automatic drive(input logic e, input logic d, input logic f);
      @(negedge clk);
      bus.en  = e;
      bus.din = d;
      bus.fs  = f;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] chans();
      return {bus.ch0, bus.ch1, bus.ch2, bus.ch3};
   endfunction

   task automatic test_reset();
      bus.en = 1'b0; bus.din = 1'b0; bus.fs = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (chans() !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_ch: got %h want 00000000", chans());
      end
      tests_run++;
      if ({bus.frame_valid, bus.locked, bus.sync_err} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_status: got %b want 000",
                  {bus.frame_valid, bus.locked, bus.sync_err});
      end
      @(negedge clk);
      rst_n = 1'b1;
      // In HUNT a bit without fs is discarded silently.
      drive(1'b1, 1'b1, 1'b0);
      tests_run++;
      if ({bus.locked, bus.sync_err} !== 2'b00) begin
         tests_failed++;
         $display("FAIL hunt_discard: got locked/err %b want 00", {bus.locked, bus.sync_err});
      end
   endtask

   task automatic test_single_frame();
      logic [31:0] f = 32'hA53CFF01;
      int early = 0;
      for (int k = 0; k < 32; k++) begin
         drive(1'b1, f[31-k], k == 0);
         if (k < 31 && bus.frame_valid) early++;
      end
      tests_run++;
      if (early != 0) begin
         tests_failed++;
         $display("FAIL single_early_valid: got %0d pulses want 0", early);
      end
      tests_run++;
      if (chans() !== 32'hA53CFF01) begin
         tests_failed++;
         $display("FAIL single_ch: got %h want a53cff01", chans());
      end
      tests_run++;
      if ({bus.frame_valid, bus.locked, bus.sync_err} !== 3'b110) begin
         tests_failed++;
         $display("FAIL single_status: got %b want 110",
                  {bus.frame_valid, bus.locked, bus.sync_err});
      end
      drive(1'b0, 1'b0, 1'b0);
      tests_run++;
      if (bus.frame_valid !== 1'b0 || chans() !== 32'hA53CFF01) begin
         tests_failed++;
         $display("FAIL single_hold: got valid %b ch %h want 0 a53cff01",
                  bus.frame_valid, chans());
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] f = 64'hA53CFF01_12345678;
      int pulses = 0, errs = 0, first = -1, second = -1;
      for (int k = 0; k < 64; k++) begin
         drive(1'b1, f[63-k], (k % 32) == 0);
         if (bus.sync_err) errs++;
         if (bus.frame_valid) begin
            pulses++;
            if (first < 0) first = k; else second = k;
         end
      end
      tests_run++;
      if (pulses != 2 || first != 31) begin
         tests_failed++;
         $display("FAIL b2b_pulses: got %0d pulses first at %0d want 2 at 31", pulses, first);
      end
      tests_run++;
      if (second - first != 32) begin
         tests_failed++;
         $display("FAIL b2b_spacing: got %0d want 32", second - first);
      end
      tests_run++;
      if (errs != 0) begin
         tests_failed++;
         $display("FAIL b2b_sync_err: got %0d pulses want 0", errs);
      end
      tests_run++;
      if (chans() !== 32'h12345678) begin
         tests_failed++;
         $display("FAIL b2b_ch: got %h want 12345678", chans());
      end
   endtask

   task automatic test_en_toggle();
      logic [31:0] f = 32'h5AC30FF0;
      int unstable = 0, valid_at = -1, late_valid = 0;
      for (int k = 0; k < 32; k++) begin
         drive(1'b1, f[31-k], k == 0);
         if (bus.frame_valid) valid_at = k;
         // Idle cycle with junk din and a stray fs that must both be ignored.
         drive(1'b0, ~f[31-k], 1'b1);
         if (bus.frame_valid) late_valid++;
         if (k < 31 && chans() !== 32'h12345678) unstable++;
      end
      tests_run++;
      if (valid_at != 31 || late_valid != 0) begin
         tests_failed++;
         $display("FAIL toggle_valid: got at %0d extra %0d want at 31 extra 0",
                  valid_at, late_valid);
      end
      tests_run++;
      if (unstable != 0) begin
         tests_failed++;
         $display("FAIL toggle_stable: got %0d changes want 0", unstable);
      end
      tests_run++;
      if (chans() !== 32'h5AC30FF0 || bus.locked !== 1'b1) begin
         tests_failed++;
         $display("FAIL toggle_ch: got %h locked %b want 5ac30ff0 1", chans(), bus.locked);
      end
   endtask

   task automatic test_misplaced_sync();
      logic [31:0] a = 32'h01020304;
      logic [31:0] b = 32'h11223344;
      for (int k = 0; k < 13; k++) drive(1'b1, a[31-k], k == 0);
      drive(1'b1, b[31], 1'b1);
      tests_run++;
      if ({bus.sync_err, bus.frame_valid, bus.locked} !== 3'b101) begin
         tests_failed++;
         $display("FAIL misplaced_err: got err/valid/locked %b want 101",
                  {bus.sync_err, bus.frame_valid, bus.locked});
      end
      tests_run++;
      if (chans() !== 32'h5AC30FF0) begin
         tests_failed++;
         $display("FAIL misplaced_hold: got %h want 5ac30ff0", chans());
      end
      drive(1'b1, b[30], 1'b0);
      tests_run++;
      if (bus.sync_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL misplaced_err_pulse: got %b want 0", bus.sync_err);
      end
      for (int k = 2; k < 32; k++) drive(1'b1, b[31-k], 1'b0);
      tests_run++;
      if (chans() !== 32'h11223344 || bus.frame_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL misplaced_resync: got %h valid %b want 11223344 1",
                  chans(), bus.frame_valid);
      end
   endtask

   task automatic test_missing_fs();
      logic [31:0] f = 32'h9ABCDEF0;
      int stray = 0;
      drive(1'b1, 1'b1, 1'b0);
      tests_run++;
      if ({bus.sync_err, bus.locked, bus.frame_valid} !== 3'b100) begin
         tests_failed++;
         $display("FAIL missing_err: got err/locked/valid %b want 100",
                  {bus.sync_err, bus.locked, bus.frame_valid});
      end
      for (int k = 0; k < 40; k++) begin
         drive(1'b1, k[0], 1'b0);
         if (bus.locked || bus.frame_valid || bus.sync_err) stray++;
      end
      tests_run++;
      if (stray != 0 || chans() !== 32'h11223344) begin
         tests_failed++;
         $display("FAIL missing_hunt: got %0d events ch %h want 0 11223344", stray, chans());
      end
      for (int k = 0; k < 32; k++) drive(1'b1, f[31-k], k == 0);
      tests_run++;
      if (chans() !== 32'h9ABCDEF0 || bus.frame_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL missing_recover: got %h valid %b want 9abcdef0 1",
                  chans(), bus.frame_valid);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] f = 32'h0F1E2D3C;
      logic [31:0] g = 32'h55AA33CC;
      int stray = 0;
      for (int k = 0; k < 20; k++) drive(1'b1, f[31-k], k == 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (chans() !== 32'h0 || {bus.frame_valid, bus.locked, bus.sync_err} !== 3'b000) begin
         tests_failed++;
         $display("FAIL async_reset: got ch %h status %b want 00000000 000",
                  chans(), {bus.frame_valid, bus.locked, bus.sync_err});
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 20; k < 32; k++) begin
         drive(1'b1, f[31-k], 1'b0);
         if (bus.frame_valid || bus.locked) stray++;
      end
      tests_run++;
      if (stray != 0) begin
         tests_failed++;
         $display("FAIL reset_no_frame: got %0d events want 0", stray);
      end
      for (int k = 0; k < 32; k++) drive(1'b1, g[31-k], k == 0);
      tests_run++;
      if (chans() !== 32'h55AA33CC || bus.frame_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_recover: got %h valid %b want 55aa33cc 1",
                  chans(), bus.frame_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_en_toggle();
      test_misplaced_sync();
      test_missing_fs();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Backstop so the run always terminates.
   initial begin
      #1000000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
Four-channel time-division demultiplexer for the serial link on the far side of the team's 4:1 channel selector/serializer. It hunts for a frame-sync marker in a serial bit stream and shifts in four consecutive slots of SLOT_W bits each. It then presents all four channel words in parallel, registered, with a one-cycle frame strobe. Loss of frame alignment is detected and reported, and the block re-synchronises automatically.

Parameters:
SLOT_W, 8, bits per channel slot (min 1); frame length FRAME_LEN = 4*SLOT_W bits

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  bit-enable; din/fs are sampled only on cycles with en=1
din  input  1  serial data bit
fs  input  1  frame sync; high with en on the first bit (ch0 MSB) of each frame
ch0  output  SLOT_W  channel 0 word (first slot in frame)
ch1  output  SLOT_W  channel 1 word
ch2  output  SLOT_W  channel 2 word
ch3  output  SLOT_W  channel 3 word (last slot in frame)
frame_valid  output  1  one-cycle pulse: ch0..ch3 just updated with a complete frame
locked  output  1  high while in RECEIVE state
sync_err  output  1  one-cycle pulse on a frame-alignment violation

Behaviour:
- Reset (async, rst_n=0):
  - state=HUNT, bit counter=0, shift register=0.
  - ch0..ch3=0, frame_valid=0, locked=0, sync_err=0.
  - Release takes effect on the next clk edge.
- en=0 cycles:
  - No state, counter or shift-register change; din and fs ignored.
  - frame_valid and sync_err still drop after their one pulse cycle.
- Bit order: ch0 first, ch3 last; each slot MSB first.
  - Frame bit k lands in channel k/SLOT_W, bit SLOT_W-1-(k mod SLOT_W).
- State HUNT (locked=0):
  - en&&!fs: discard the bit.
  - en&&fs: the bit is frame bit 0; go to RECEIVE with counter=1.
- State RECEIVE (locked=1); counter cnt = index of the next expected bit:
  - cnt=0, en&&fs: normal next-frame start, bit stored, cnt=1.
  - cnt=0, en&&!fs: sync_err=1 next cycle, state=HUNT, bit discarded.
  - 0<cnt, en&&fs: misplaced sync. sync_err=1 next cycle, partial frame discarded, this bit taken as frame bit 0, cnt=1, stay in RECEIVE. ch* are not updated.
  - 0<cnt<FRAME_LEN-1, en&&!fs: bit stored, cnt+1.
  - cnt=FRAME_LEN-1, en&&!fs: last bit stored. On the same edge, ch0..ch3 are loaded with the full frame, frame_valid=1 for exactly the following cycle, and cnt wraps to 0.
- Latency: ch* and frame_valid are visible in the cycle directly after the edge that samples the last frame bit.
- ch0..ch3 hold their value until the next completed frame. Outputs never show partial frames.
- Back-to-back frames with en=1 continuously: frame_valid pulses every FRAME_LEN cycles. This holds at SLOT_W=1 (every 4 cycles).
- sync_err and frame_valid are never high in the same cycle.
- Reset mid-frame: partial data is lost, outputs are cleared, and the next frame requires fs from HUNT.

Test Plan:
- SLOT_W=8, en=1, reset release then fs on first bit of frame A5,3C,FF,01 -> after 32nd bit: ch0=8'hA5, ch1=8'h3C, ch2=8'hFF, ch3=8'h01, frame_valid one cycle, locked=1.
- Two back-to-back frames (A5,3C,FF,01 then 12,34,56,78), en=1 throughout -> frame_valid exactly 32 cycles apart; second set of values replaces the first; sync_err never asserted.
- Same frame with en toggling 1,0 every cycle -> identical ch values; frame_valid occurs after the 32nd enabled bit; outputs stable during en=0.
- fs re-asserted at bit 13 of a frame -> sync_err pulse; ch* keep their previous values. A full frame from that bit (11,22,33,44) -> ch0..ch3 = 11,22,33,44.
- After a good frame, fs missing at next frame start -> sync_err pulse, locked=0; din ignored until fs returns; next complete frame decoded correctly.
- rst_n pulsed low asynchronously (between edges) at bit 20 of a frame -> all outputs 0 immediately; no frame_valid for that frame.
